// File: rtl/add_sub_sequencer.sv
// rtl/add_sub_sequencer.sv - button-driven operand capture / execute / show sequencer for a 6-bit add/sub datapath
// Optional feature macro: ADD_SUB_SEQ_ACCUM_EN (chained accumulation with sticky overflow).
module add_sub_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] switches,
  input  logic       mode,
  input  logic       button,
  input  logic [5:0] dp_result,
  input  logic       dp_of,
  output logic [5:0] dp_a,
  output logic [5:0] dp_b,
  output logic       dp_sub,
  output logic [5:0] result,
  output logic       of_led,
  output logic       result_valid,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    EXEC  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             deb_level;
  logic             deb_prev;
  logic             press;
  logic [CNT_W-1:0] count;

  state_t     state;
  state_t     next_state;
  logic [5:0] a_next;
  logic [5:0] b_next;
  logic       sub_next;
  logic [5:0] result_next;
  logic       of_next;
  logic       valid_next;

  // Button levels are kept raw (1 = released); press fires one cycle after the debounced fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1    <= 1'b1;
      sync_2    <= 1'b1;
      deb_level <= 1'b1;
      deb_prev  <= 1'b1;
      count     <= '0;
      press     <= 1'b0;
    end else begin
      sync_1   <= button;
      sync_2   <= sync_1;
      deb_prev <= deb_level;
      press    <= deb_prev & ~deb_level;
      if (sync_2 == deb_level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        count     <= '0;
        deb_level <= sync_2;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= GET_A;
      dp_a         <= '0;
      dp_b         <= '0;
      dp_sub       <= 1'b0;
      result       <= '0;
      of_led       <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= next_state;
      dp_a         <= a_next;
      dp_b         <= b_next;
      dp_sub       <= sub_next;
      result       <= result_next;
      of_led       <= of_next;
      result_valid <= valid_next;
    end
  end

  always_comb begin
    next_state  = state;
    a_next      = dp_a;
    b_next      = dp_b;
    sub_next    = dp_sub;
    result_next = result;
    of_next     = of_led;
    valid_next  = 1'b0;
    case (state)
      GET_A: begin
        if (press) begin
          a_next     = switches;
          next_state = GET_B;
`ifdef ADD_SUB_SEQ_ACCUM_EN
          of_next    = 1'b0;
`endif
        end
      end
      GET_B: begin
        if (press) begin
          b_next     = switches;
          sub_next   = mode;
          next_state = EXEC;
        end
      end
      EXEC: begin
        // A press landing here is dropped: EXEC never looks at press.
        result_next = dp_result;
`ifdef ADD_SUB_SEQ_ACCUM_EN
        of_next     = of_led | dp_of;
`else
        of_next     = dp_of;
`endif
        valid_next  = 1'b1;
        next_state  = SHOW;
      end
      SHOW: begin
        if (press) begin
`ifdef ADD_SUB_SEQ_ACCUM_EN
          a_next     = result;
          next_state = GET_B;
`else
          next_state = GET_A;
`endif
        end
      end
      default: next_state = GET_A;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_add_sub_sequencer.sv
// tb/tb_add_sub_sequencer.sv - directed self-checking bench for add_sub_sequencer
module tb_add_sub_sequencer;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] switches;
  logic       mode;
  logic       button;
  logic [5:0] dp_result;
  logic       dp_of;
  logic [5:0] dp_a;
  logic [5:0] dp_b;
  logic       dp_sub;
  logic [5:0] result;
  logic       of_led;
  logic       result_valid;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;
  int rv_count = 0;
  int rv_base;
  bit found;

  add_sub_sequencer #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst(rst), .switches(switches), .mode(mode), .button(button),
    .dp_result(dp_result), .dp_of(dp_of), .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub),
    .result(result), .of_led(of_led), .result_valid(result_valid), .phase(phase)
  );

  always #5 clk = ~clk;

  // External datapath: 6-bit two's-complement add/sub with signed overflow.
  assign dp_result = dp_sub ? (dp_a - dp_b) : (dp_a + dp_b);
  assign dp_of = dp_sub ? ((dp_a[5] != dp_b[5]) && (dp_result[5] != dp_a[5]))
                        : ((dp_a[5] == dp_b[5]) && (dp_result[5] != dp_a[5]));

  always @(posedge clk) begin
    #1;
    if (result_valid) rv_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic press_button();
    button = 1'b0;
    repeat (N + 4) @(negedge clk);
    button = 1'b1;
    repeat (N + 6) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_phase"}, phase, 0);
    check({tag, "_dp_a"}, dp_a, 0);
    check({tag, "_dp_b"}, dp_b, 0);
    check({tag, "_dp_sub"}, dp_sub, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_of_led"}, of_led, 0);
    check({tag, "_valid"}, result_valid, 0);
  endtask

  initial begin
    rst = 1'b1; button = 1'b1; switches = 6'd0; mode = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 5 + 3 with first-press latency check
    switches = 6'd5;
    button = 1'b0;
    repeat (N + 3) @(negedge clk);
    check("lat_before", phase, 0);
    @(negedge clk);
    check("lat_at", phase, 1);
    button = 1'b1;
    repeat (N + 6) @(negedge clk);
    check("t1_dp_a", dp_a, 5);
    switches = 6'd3; mode = 1'b0;
    rv_base = rv_count;
    press_button();
    switches = 6'h2a;
    check("t1_dp_b", dp_b, 3);
    check("t1_dp_sub", dp_sub, 0);
    check("t1_result", result, 8);
    check("t1_of", of_led, 0);
    check("t1_phase", phase, 3);
    check("t1_pulses", rv_count - rv_base, 1);
    check("t1_dp_a_hold", dp_a, 5);
    press_button();
`ifdef ADD_SUB_SEQ_ACCUM_EN
    check("show_press_phase", phase, 1);
    check("show_press_dp_a", dp_a, 8);
    switches = 6'd2; mode = 1'b0;
    press_button();
    check("accum_result", result, 10);
    check("accum_phase", phase, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`else
    check("show_press_phase", phase, 0);
`endif

    // 31 + 1 overflows positive
    switches = 6'd31; press_button();
    switches = 6'd1; mode = 1'b0; press_button();
    check("t2_result", result, 6'b100000);
    check("t2_of", of_led, 1);
`ifdef ADD_SUB_SEQ_ACCUM_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`else
    press_button();
`endif

    // -32 - 1 overflows negative
    switches = 6'b100000; press_button();
    switches = 6'd1; mode = 1'b1; press_button();
    check("t3_dp_sub", dp_sub, 1);
    check("t3_result", result, 6'd31);
    check("t3_of", of_led, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mode = 1'b0;
    @(negedge clk);

    // bounce: low 3, high 1, low -> transition at edge 7 after final fall
    switches = 6'd7;
    button = 1'b0;
    repeat (3) @(negedge clk);
    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
    repeat (7) @(negedge clk);
    check("bounce_before", phase, 0);
    @(negedge clk);
    check("bounce_at", phase, 1);
    repeat (50) @(negedge clk);
    check("held_phase", phase, 1);
    check("held_dp_a", dp_a, 7);
    button = 1'b1;
    repeat (N + 6) @(negedge clk);

    // reset during EXEC, button held through reset release
    switches = 6'd2; mode = 1'b0;
    rv_base = rv_count;
    button = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (phase == 2'd2) found = 1'b1;
    end
    check("exec_reached", found, 1);
    rst = 1'b1;
    #1;
    check_zero("exec_rst");
    repeat (3) @(negedge clk);
    check("exec_rst_pulses", rv_count - rv_base, 0);
    rst = 1'b0;
    repeat (N + 3) @(negedge clk);
    check("rst_hold_before", phase, 0);
    @(negedge clk);
    check("rst_hold_at", phase, 1);
    check("rst_hold_dp_a", dp_a, 2);
    repeat (20) @(negedge clk);
    check("rst_hold_once", phase, 1);
    button = 1'b1;
    repeat (N + 6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/add_sub_sequencer.md
# add_sub_sequencer

Sequences the shared 6-bit two's-complement add/subtract datapath from a single push-button and six slide switches. Each debounced press advances a four-state FSM: capture operand A, capture operand B and the add/sub mode, execute one datapath cycle, then hold the result. The block sits between the board I/O and the adder/subtractor. It drives the datapath operands and registers the datapath result and overflow for the display and LED logic.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required before a button level change is accepted; minimum 2.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `switches` in 6: operand entry, two's complement.
- `mode` in 1: 0 = add, 1 = subtract. Sampled only on the B-capture press.
- `button` in 1: raw push-button, active-low, asynchronous and bouncy.
- `dp_result` in 6: datapath result, combinational from `dp_a`/`dp_b`/`dp_sub`.
- `dp_of` in 1: datapath signed overflow.
- `dp_a` out 6: operand A register.
- `dp_b` out 6: operand B register.
- `dp_sub` out 1: latched mode.
- `result` out 6: registered result.
- `of_led` out 1: registered overflow.
- `result_valid` out 1: one-cycle pulse when `result` updates.
- `phase` out 2: FSM state. GET_A = 0, GET_B = 1, EXEC = 2, SHOW = 3.

## Operation
- Button front end:
  - 2-flop synchronizer on `button`.
  - Debounced level resets to "released".
  - Counter increments while the synchronized level differs from the debounced level; it clears to 0 whenever the levels match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - `press` is a registered one-cycle pulse on the released→pressed transition of the debounced level. Release generates nothing.
- FSM:
  - GET_A: on `press`, `dp_a` <= `switches`, go to GET_B.
  - GET_B: on `press`, `dp_b` <= `switches`, `dp_sub` <= `mode`, go to EXEC.
  - EXEC: unconditional single cycle. `result` <= `dp_result`, `of_led` <= `dp_of`, `result_valid` = 1 for this transition only, go to SHOW.
  - SHOW: on `press`, go to GET_A. `result` and `of_led` keep their values until the next EXEC.
- A press arriving during EXEC is impossible, because presses are at least `DEBOUNCE_CYCLES` apart. If one does occur, it is ignored.
- `switches` and `mode` are ignored except at their capture edges.
- No arithmetic happens in this block. Widths pass through unchanged, and the sign/overflow meaning is owned by the datapath.

## Timing
- Reset values: `dp_a` = 0, `dp_b` = 0, `dp_sub` = 0, `result` = 0, `of_led` = 0, `result_valid` = 0, `phase` = 0 (GET_A). Debouncer counter = 0, debounced level = released, synchronizer = 1.
- Press latency:
  - Edge 0 is the first `clk` edge that samples `button` = 0.
  - The button stays low from edge 0.
  - The FSM transition occurs at edge `DEBOUNCE_CYCLES` + 3.
- Bounce: any return to high before the count completes restarts the count from 0 on the next stable low.
- EXEC to SHOW: exactly one cycle. `result` is valid the cycle after `phase` = 2.
- Reset mid-operation: all registers return immediately to their reset values. If the button is held low through reset release, it is accepted as one new press after the full debounce.
- A held button produces exactly one press. A second press requires a debounced release first.

## Configuration
- `ADD_SUB_SEQ_ACCUM_EN` defined:
  - A press in SHOW loads `dp_a` <= `result` and goes to GET_B (chained accumulation), not GET_A.
  - `of_led` becomes sticky: it is ORed with each new `dp_of`. It clears only on reset or on a GET_A capture.
- Not defined: SHOW → GET_A as specified above, and `of_led` is not sticky.

## Test plan
- Sim with `DEBOUNCE_CYCLES` = 4.
- Reset, `switches` = 6'd5 press, `switches` = 6'd3, `mode` = 0 press → `dp_a` = 5, `dp_b` = 3, `result` = 8, `of_led` = 0, single `result_valid` pulse, `phase` = 3.
- A = 6'd31, B = 6'd1, `mode` = 0 → `result` = 6'b100000, `of_led` = 1 (datapath model). Next cycle A = 6'b100000 (−32), B = 1, `mode` = 1 → `of_led` = 1.
- Button low 3 cycles, high 1, low 10 → exactly one press. The FSM transition falls 7 edges after the final fall (edge 0 = first sample low after the final fall, transition at edge 4 + 3).
- Hold the button low for 50 cycles → one transition only. Hold low through reset deassertion → outputs 0 during reset, then one press after debounce.
- Assert `rst` while `phase` = 2 → all outputs 0 the same cycle, no `result_valid`.
- `ADD_SUB_SEQ_ACCUM_EN`: compute 5 + 3, press in SHOW (`phase` goes to 1, `dp_a` = 8), B = 2 add → `result` = 10.
